// File: rtl/reg_bank_param_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_param_if
// Description : Write/read bus bundle for the parametrised register bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_param_if #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 2,
    parameter int OPCODE_BITS = 4
);
    logic                           we;
    logic [ADDR_W-1:0]              wsel;
    logic [2:0]                     op;
    logic [WIDTH-1:0]               din;
    logic [ADDR_W-1:0]              rsel_a;
    logic [ADDR_W-1:0]              rsel_b;
    logic [WIDTH-1:0]               dout_a;
    logic [WIDTH-1:0]               dout_b;
    logic [OPCODE_BITS-1:0]         instruction;
    logic [WIDTH-OPCODE_BITS-1:0]   address;
    logic                           carry;
    logic                           zero;

    modport master (
        output we, wsel, op, din, rsel_a, rsel_b,
        input  dout_a, dout_b, instruction, address, carry, zero
    );

    modport slave (
        input  we, wsel, op, din, rsel_a, rsel_b,
        output dout_a, dout_b, instruction, address, carry, zero
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_param.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_param
// Description : Register bank with one operating write port, two async read
//               ports, carry/zero flags and an opcode/operand view.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_param #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 2,
    parameter int OPCODE_BITS = 4,
    parameter int IR_INDEX    = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    reg_bank_param_if.slave    bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int OPW   = WIDTH - OPCODE_BITS;

    localparam logic [2:0] c_OP_HOLD  = 3'b000;
    localparam logic [2:0] c_OP_LOAD  = 3'b001;
    localparam logic [2:0] c_OP_CLEAR = 3'b010;
    localparam logic [2:0] c_OP_INC   = 3'b011;
    localparam logic [2:0] c_OP_DEC   = 3'b100;
    localparam logic [2:0] c_OP_SHL   = 3'b101;
    localparam logic [2:0] c_OP_SHR   = 3'b110;
    localparam logic [2:0] c_OP_LDOP  = 3'b111;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             zero_d;

    always_comb begin
        cur_val = regs_q[bus.wsel];
        res_d   = cur_val;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (bus.op)
            c_OP_HOLD: ;
            c_OP_LOAD: begin
                res_d   = bus.din;
                carry_d = 1'b0;
            end
            c_OP_CLEAR: begin
                res_d   = '0;
                carry_d = 1'b0;
            end
            c_OP_INC: begin
                res_d   = cur_val + WIDTH'(1);
                carry_d = (cur_val == {WIDTH{1'b1}});
            end
            c_OP_DEC: begin
                res_d   = cur_val - WIDTH'(1);
                carry_d = (cur_val == '0);
            end
            c_OP_SHL: begin
                res_d   = {cur_val[WIDTH-2:0], 1'b0};
                carry_d = cur_val[WIDTH-1];
            end
            c_OP_SHR: begin
                res_d   = {1'b0, cur_val[WIDTH-1:1]};
                carry_d = cur_val[0];
            end
            c_OP_LDOP: begin
                res_d   = {cur_val[WIDTH-1 -: OPCODE_BITS], bus.din[OPW-1:0]};
                carry_d = 1'b0;
            end
            default: ;
        endcase
        // Every op other than HOLD re-evaluates zero on the full new value
        if (bus.op != c_OP_HOLD) begin
            zero_d = (res_d == '0);
        end
    end

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[i] <= '0;
                end else if (bus.we && (bus.wsel == ADDR_W'(i))) begin
                    regs_q[i] <= res_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (bus.we) begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.dout_a      = regs_q[bus.rsel_a];
    assign bus.dout_b      = regs_q[bus.rsel_b];
    assign bus.instruction = regs_q[IR_INDEX][WIDTH-1 -: OPCODE_BITS];
    assign bus.address     = regs_q[IR_INDEX][OPW-1:0];
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_param
// Description : Self-checking bench for reg_bank_param against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_param;
    localparam int WIDTH       = 8;
    localparam int ADDR_W      = 2;
    localparam int OPCODE_BITS = 4;
    localparam int NREGS       = 4;
    localparam int MODV        = 256;
    localparam int OPMOD       = 16;

    logic clk;
    logic rst_n;

    reg_bank_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OPCODE_BITS(OPCODE_BITS)) bus ();

    reg_bank_param #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .OPCODE_BITS(OPCODE_BITS), .IR_INDEX(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned m_reg [NREGS];
    int unsigned m_c;
    int unsigned m_z;
    int          n_checks;
    int          n_fail;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = 0;
        m_c = 0;
        m_z = 1;
    endtask

    // Sweeps every register through both read ports, then checks flags and IR view
    task automatic check_state(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            bus.rsel_a = ADDR_W'(i);
            bus.rsel_b = ADDR_W'(NREGS - 1 - i);
            #1;
            check_value({tag, "_dout_a"}, 32'(bus.dout_a), m_reg[i]);
            check_value({tag, "_dout_b"}, 32'(bus.dout_b), m_reg[NREGS - 1 - i]);
        end
        check_value({tag, "_carry"}, 32'(bus.carry), m_c);
        check_value({tag, "_zero"}, 32'(bus.zero), m_z);
        check_value({tag, "_instr"}, 32'(bus.instruction), m_reg[0] / OPMOD);
        check_value({tag, "_addr"}, 32'(bus.address), m_reg[0] % OPMOD);
    endtask

    task automatic step(input string tag, input bit we_v, input int sel, input int opv, input int d);
        int unsigned r;
        int unsigned nv;
        bus.we     = we_v;
        bus.wsel   = ADDR_W'(sel);
        bus.op     = 3'(opv);
        bus.din    = WIDTH'(d);
        bus.rsel_a = ADDR_W'(sel);
        bus.rsel_b = ADDR_W'(sel);
        #1;
        check_value({tag, "_prewrite"}, 32'(bus.dout_a), m_reg[sel]);
        @(posedge clk);
        if (we_v && opv != 0) begin
            r = m_reg[sel];
            nv = r;
            case (opv)
                1: begin nv = d % MODV;                     m_c = 0; end
                2: begin nv = 0;                            m_c = 0; end
                3: begin nv = (r + 1) % MODV;               m_c = (r == MODV - 1) ? 1 : 0; end
                4: begin nv = (r + MODV - 1) % MODV;        m_c = (r == 0) ? 1 : 0; end
                5: begin nv = (r * 2) % MODV;               m_c = (r >= MODV / 2) ? 1 : 0; end
                6: begin nv = r / 2;                        m_c = r % 2; end
                default: begin nv = (r / OPMOD) * OPMOD + (d % OPMOD); m_c = 0; end
            endcase
            m_reg[sel] = nv;
            m_z = (nv == 0) ? 1 : 0;
        end
        @(negedge clk);
        bus.we = 1'b0;
        check_state(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n      = 1'b0;
        bus.we     = 1'b0;
        bus.wsel   = '0;
        bus.op     = '0;
        bus.din    = '0;
        bus.rsel_a = '0;
        bus.rsel_b = '0;
        repeat (2) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        step("load_a5", 1, 2, 1, 8'hA5);
        step("ld_ff",   1, 1, 1, 8'hFF);
        step("inc_wrap", 1, 1, 3, 0);
        step("dec_wrap", 1, 1, 4, 0);
        step("dec_fe",  1, 1, 4, 0);
        step("ld_81",   1, 3, 1, 8'h81);
        step("shl",     1, 3, 5, 0);
        step("shr1",    1, 3, 6, 0);
        step("shr0",    1, 3, 6, 0);
        step("ld_3c",   1, 0, 1, 8'h3C);
        step("ldop",    1, 0, 7, 8'hF7);
        step("ld_r1",   1, 1, 1, 8'hFF);
        step("clear",   1, 2, 2, 8'h55);
        for (int k = 0; k < 5; k++) step("we0_inc", 0, k % NREGS, 3, 0);
        step("hold",    1, 1, 0, 8'h12);

        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 9) != 0), int'($urandom_range(0, NREGS - 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end

        // Asynchronous reset mid-cycle with a write pending: nothing may survive
        for (int i = 0; i < NREGS; i++) step("preload", 1, i, 1, 8'h11 * (i + 1));
        bus.we   = 1'b1;
        bus.wsel = 2'd1;
        bus.op   = 3'b001;
        bus.din  = 8'h77;
        #3;
        rst_n = 1'b0;
        model_reset();
        check_state("async_rst");
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        check_state("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1, 0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
